mem_stage: RTL and testbench

Pipeline MEM stage of the 32-bit RISC-V core. It consumes the EX/MEM register outputs of the execute stage and performs loads and stores through a request/ready data-memory port. It stalls upstream while an access is outstanding, then loads the MEM/WB pipeline register that feeds writeback. Misaligned and timed-out accesses are turned into bubbles and flagged in sticky error bits.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_req_fsm.sv | 64 ++++++
 rtl/mem_stage.sv | 75 +++++++
 tb/tb_mem_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared MEM-stage control encodings and FSM state type
package mem_stage_pkg;
    localparam int CTRL_MEM_READ  = 0;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_REG_WRITE = 2;
    localparam int CTRL_WB_SEL    = 3;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    typedef enum logic {IDLE, BUSY} mem_state_t;
    function automatic logic [2:0] ctrl_wb_pack(input logic [4:0] ctrl);
        logic [1:0] sel;
        sel = ctrl[CTRL_WB_SEL +: 2];
        return {(sel == 2'b11) ? WB_ALU : sel, ctrl[CTRL_REG_WRITE]};
    endfunction
endpackage

// File: rtl/mem_req_fsm.sv
// mem_req_fsm: data-memory request sequencing, timeout, stall and error detection
module mem_req_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data1,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        complete,
    output logic        misalign,
    output logic        timeout
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    mem_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic mem_op, aligned, busy, last, start;

    always_comb begin
        mem_op   = mem_read | mem_write;
        aligned  = alu_result[1:0] == 2'b00;
        busy     = state == BUSY;
        last     = cnt == LAST;
        // gating with reset_n keeps stall low while the stage is held in reset
        start    = reset_n && !busy && mem_op && aligned;
        misalign = reset_n && !busy && mem_op && !aligned;
        complete = busy && dmem_ready;
        timeout  = busy && !dmem_ready && last;
        stall    = start || (busy && !dmem_ready && !last);
        dmem_req = busy;
        state_nx = start ? BUSY : (complete || timeout) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                cnt        <= '0;
                dmem_we    <= mem_write;
                dmem_addr  <= {alu_result[31:2], 2'b00};
                dmem_wdata <= write_data1;
            end else if (busy && !complete && !timeout) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RISC-V MEM pipeline stage with MEM/WB register and sticky error flags
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  ctrl_mem,
    input  logic [31:0] rd_mem,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data1,
    input  logic [31:0] pc4_mem,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [2:0]  ctrl_wb,
    output logic [31:0] rd_wb,
    output logic [31:0] alu_result_wb,
    output logic [31:0] read_data_wb,
    output logic [31:0] pc4_wb,
    output logic        misalign_err,
    output logic        bus_err,
    output logic [31:0] err_addr
);
    logic complete, misalign, timeout, bubble;

    mem_req_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_read   (ctrl_mem[CTRL_MEM_READ]),
        .mem_write  (ctrl_mem[CTRL_MEM_WRITE]),
        .alu_result (alu_result),
        .write_data1(write_data1),
        .dmem_ready (dmem_ready),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .complete   (complete),
        .misalign   (misalign),
        .timeout    (timeout)
    );

    // every memory op is a bubble until the cycle it completes
    assign bubble = (ctrl_mem[CTRL_MEM_READ] || ctrl_mem[CTRL_MEM_WRITE]) && !complete;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_wb       <= '0;
            rd_wb         <= '0;
            alu_result_wb <= '0;
            read_data_wb  <= '0;
            pc4_wb        <= '0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
            err_addr      <= '0;
        end else begin
            ctrl_wb       <= bubble ? 3'b000 : ctrl_wb_pack(ctrl_mem);
            rd_wb         <= rd_mem;
            alu_result_wb <= alu_result;
            pc4_wb        <= pc4_mem;
            if (complete && !dmem_we) read_data_wb <= dmem_rdata;
            if (misalign) misalign_err <= 1'b1;
            if (timeout) bus_err <= 1'b1;
            if ((misalign || timeout) && !(misalign_err || bus_err))
                err_addr <= misalign ? alu_result : dmem_addr;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  ctrl_mem = '0;
    logic [31:0] rd_mem = '0, alu_result = '0, write_data1 = '0, pc4_mem = '0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [2:0]  ctrl_wb;
    logic [31:0] rd_wb, alu_result_wb, read_data_wb, pc4_wb, err_addr;
    logic        misalign_err, bus_err;
    int checks = 0, errors = 0;

    localparam logic [4:0] C_ALU   = 5'b00100;
    localparam logic [4:0] C_LOAD  = 5'b01101;
    localparam logic [4:0] C_STORE = 5'b00010;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
        .alu_result(alu_result), .write_data1(write_data1), .pc4_mem(pc4_mem),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .ctrl_wb(ctrl_wb), .rd_wb(rd_wb), .alu_result_wb(alu_result_wb),
        .read_data_wb(read_data_wb), .pc4_wb(pc4_wb),
        .misalign_err(misalign_err), .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [4:0] c, input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] rdata);
        int stall_cnt = 0, req_cnt = 0;
        bit done = 0;
        ctrl_mem = c; alu_result = a; write_data1 = wd;
        for (int k = 0; k < 40 && !done; k++) begin
            if (dmem_req) begin
                req_cnt++;
                check("req_addr", dmem_addr, a);
                check("req_we", 32'(dmem_we), 32'(c[1]));
                check("req_wdata", dmem_wdata, wd);
            end
            dmem_ready = dmem_req && req_cnt == waits + 1;
            dmem_rdata = dmem_ready ? rdata : 32'h0;
            #1;
            if (stall) stall_cnt++;
            done = dmem_ready;
            tick();
        end
        dmem_ready = 1'b0;
        ctrl_mem = '0;
        check("acc_done", 32'(done), 32'd1);
        check("acc_stall_cycles", stall_cnt, waits + 1);
        check("acc_req_cycles", req_cnt, waits + 1);
    endtask

    initial begin
        int req_cnt, stall_cnt;
        bit aborted;
        tick();
        tick();
        check("rst_stall", 32'(stall), 0);
        check("rst_req", 32'(dmem_req), 0);
        check("rst_ctrl_wb", 32'(ctrl_wb), 0);
        check("rst_errs", {30'd0, misalign_err, bus_err}, 0);
        check("rst_read_data", read_data_wb, 0);
        reset_n = 1'b1;

        ctrl_mem = C_ALU; alu_result = 32'h1234; rd_mem = 32'd5; pc4_mem = 32'h44;
        #1 check("alu_stall", 32'(stall), 0);
        tick();
        check("alu_ctrl_wb", 32'(ctrl_wb), 32'b001);
        check("alu_result_wb", alu_result_wb, 32'h1234);
        check("alu_rd_wb", rd_wb, 32'd5);
        check("alu_pc4_wb", pc4_wb, 32'h44);
        check("alu_req", 32'(dmem_req), 0);

        rd_mem = 32'd7;
        access(C_LOAD, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        check("ld_read_data", read_data_wb, 32'hDEADBEEF);
        check("ld_ctrl_wb", 32'(ctrl_wb), 32'b011);
        check("ld_rd_wb", rd_wb, 32'd7);
        check("ld_req_after", 32'(dmem_req), 0);

        access(C_STORE, 32'h200, 32'hCAFEF00D, 3, 32'h0);
        check("st_read_data_kept", read_data_wb, 32'hDEADBEEF);
        check("st_ctrl_wb", 32'(ctrl_wb), 32'b000);

        ctrl_mem = C_LOAD; alu_result = 32'h103;
        #1 check("mis_stall", 32'(stall), 0);
        tick();
        check("mis_req", 32'(dmem_req), 0);
        check("mis_err", 32'(misalign_err), 1);
        check("mis_err_addr", err_addr, 32'h103);
        check("mis_ctrl_wb", 32'(ctrl_wb), 0);
        ctrl_mem = C_STORE; alu_result = 32'h202;
        tick();
        check("mis2_err_addr_first", err_addr, 32'h103);
        ctrl_mem = '0;

        dmem_ready = 1'b1; dmem_rdata = 32'h5555AAAA;
        #1 check("idle_ready_stall", 32'(stall), 0);
        tick();
        dmem_ready = 1'b0;
        check("idle_ready_req", 32'(dmem_req), 0);
        check("idle_ready_data", read_data_wb, 32'hDEADBEEF);

        access(C_LOAD, 32'h180, 32'h0, 15, 32'h0BADF00D);
        check("late_bus_err", 32'(bus_err), 0);
        check("late_read_data", read_data_wb, 32'h0BADF00D);

        ctrl_mem = C_LOAD; alu_result = 32'h300;
        req_cnt = 0; stall_cnt = 0; aborted = 0;
        for (int k = 0; k < 40 && !aborted; k++) begin
            if (dmem_req) req_cnt++;
            #1;
            if (stall) stall_cnt++;
            aborted = dmem_req && !stall;
            tick();
        end
        ctrl_mem = '0;
        check("to_aborted", 32'(aborted), 1);
        check("to_req_cycles", req_cnt, 16);
        check("to_stall_cycles", stall_cnt, 16);
        check("to_bus_err", 32'(bus_err), 1);
        check("to_ctrl_wb", 32'(ctrl_wb), 0);
        check("to_req_drop", 32'(dmem_req), 0);
        check("to_err_addr_first", err_addr, 32'h103);

        ctrl_mem = C_LOAD; alu_result = 32'h400;
        tick();
        check("rb_req", 32'(dmem_req), 1);
        reset_n = 1'b0;
        #1;
        check("rb_req_drop", 32'(dmem_req), 0);
        check("rb_stall", 32'(stall), 0);
        check("rb_ctrl_wb", 32'(ctrl_wb), 0);
        check("rb_read_data", read_data_wb, 0);
        check("rb_err_addr", err_addr, 0);
        check("rb_errs", {30'd0, misalign_err, bus_err}, 0);
        check("rb_alu_wb", alu_result_wb, 0);
        ctrl_mem = '0;
        tick();
        reset_n = 1'b1;
        access(C_LOAD, 32'h104, 32'h0, 1, 32'h12345678);
        check("post_rst_data", read_data_wb, 32'h12345678);
        check("post_rst_ctrl_wb", 32'(ctrl_wb), 32'b011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
